// File: rtl/pc_capture_pkg.sv
// ---------------------------------------------------------------------------
// pc_capture_pkg
// Shared definitions for the PC capture front end of the seven-segment
// display path.
//   state_t   : button-handling FSM states (3-bit encoding)
//   cntWidth  : width of the single shared cycle counter, sized for the
//               largest of the three timing parameters
// ---------------------------------------------------------------------------
package pc_capture_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        PRESSED     = 3'd2,
        REPEAT      = 3'd3,
        DEB_RELEASE = 3'd4
    } state_t;

    // The counter only ever reaches (parameter - 1), so clog2 of the
    // largest parameter is always wide enough, even for powers of two.
    function automatic int cntWidth(input int debCycles,
                                    input int holdCycles,
                                    input int repCycles);
        int maxCycles;
        maxCycles = debCycles;
        if (holdCycles > maxCycles) maxCycles = holdCycles;
        if (repCycles > maxCycles) maxCycles = repCycles;
        return $clog2(maxCycles);
    endfunction

endpackage

// File: rtl/pc_capture_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchroniser for a raw asynchronous level.
//   clock : system clock
//   reset : asynchronous active-high reset, both flops clear to 0
//   d_i   : raw asynchronous input
//   q_o   : synchronised level, two cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pc_capture.sv
// ---------------------------------------------------------------------------
// pc_capture
// Debounces a push-button, samples the CPU program counter on each accepted
// press, and presents the selected 16-bit half to the display driver. While
// the button stays held the PC is re-sampled periodically (hold-to-repeat).
//   clock   : system clock
//   reset   : asynchronous active-high reset
//   btn     : raw button level (asynchronous)
//   sw      : raw half select (asynchronous), 1 = pc_in[31:16], 0 = pc_in[15:0]
//   pc_in   : live CPU program counter, synchronous to clock
//   pc_out  : captured half-word
//   capture : one-cycle pulse in the cycle pc_out takes a new value
//   valid   : set by the first capture, held until reset
// ---------------------------------------------------------------------------
module pc_capture
    import pc_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn,
    input  logic        sw,
    input  logic [31:0] pc_in,
    output logic [15:0] pc_out,
    output logic        capture,
    output logic        valid
);

    localparam int CW = cntWidth(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    logic btn_s;
    logic sw_s;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   pc_out_q;
    logic          capture_q;
    logic          valid_q;
    logic          do_capture;

    sync_2ff u_sync_btn (
        .clock (clock),
        .reset (reset),
        .d_i   (btn),
        .q_o   (btn_s)
    );

    sync_2ff u_sync_sw (
        .clock (clock),
        .reset (reset),
        .d_i   (sw),
        .q_o   (sw_s)
    );

    // Next-state logic. The counter increments by default and is cleared on
    // every state change; transitions fire strictly on equality so cnt never
    // passes its parameter minus one.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        do_capture = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s) state_d = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    cnt_d      = '0;
                    do_capture = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d    = REPEAT;
                    cnt_d      = '0;
                    do_capture = 1'b1;
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d      = '0;
                    do_capture = 1'b1;
                end
            end
            DEB_RELEASE: begin
                // A bounce back high resumes the held press without a new capture.
                if (btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture registers. The half select is applied at the capture instant,
    // so later switch changes leave the displayed value alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_out_q  <= '0;
            capture_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            capture_q <= do_capture;
            if (do_capture) begin
                pc_out_q <= sw_s ? pc_in[31:16] : pc_in[15:0];
                valid_q  <= 1'b1;
            end
        end
    end

    assign pc_out  = pc_out_q;
    assign capture = capture_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_pc_capture.sv
// ---------------------------------------------------------------------------
// tb_pc_capture
// Directed bench for pc_capture with DEBOUNCE_CYCLES=4, HOLD_CYCLES=16,
// REPEAT_CYCLES=8. Inputs change 1 ns after the rising edge; outputs are read
// at the same point, so each row/tick observes the result of one edge.
// With these parameters a press set before tick 1 shows its capture after
// tick 7 (2 synchroniser cycles, 1 in IDLE, 4 in DEB_PRESS); the hold capture
// follows 16 ticks later and repeats every 8 after that.
// ---------------------------------------------------------------------------
module tb_pc_capture;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int REP  = 8;

    logic        clock;
    logic        reset;
    logic        btn;
    logic        sw;
    logic [31:0] pc_in;
    logic [15:0] pc_out;
    logic        capture;
    logic        valid;

    int checkCount;
    int passCount;
    int cyc;
    int adjErr;
    logic prevCap;

    int          capCyc[$];
    logic [15:0] capPc[$];

    typedef struct {
        logic        btn;
        logic        sw;
        logic [31:0] pc;
        logic        expCap;
        logic        expValid;
        logic [15:0] expPc;
    } vec_t;

    vec_t vecs[18];

    pc_capture #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .btn     (btn),
        .sw      (sw),
        .pc_in   (pc_in),
        .pc_out  (pc_out),
        .capture (capture),
        .valid   (valid)
    );

    // Free-running clock, 10 ns period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle counter used to timestamp capture pulses.
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Capture monitor: logs every pulse with its cycle and value, and flags
    // any pulse that is high on two consecutive cycles.
    initial begin
        adjErr  = 0;
        prevCap = 1'b0;
    end
    always @(negedge clock) begin
        if (capture === 1'b1) begin
            capCyc.push_back(cyc);
            capPc.push_back(pc_out);
            if (prevCap === 1'b1) adjErr = adjErr + 1;
        end
        prevCap = capture;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic b, input logic s, input logic [31:0] p);
        btn   = b;
        sw    = s;
        pc_in = p;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount = checkCount + 1;
        if (act === exp) passCount = passCount + 1;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clearLog();
        capCyc.delete();
        capPc.delete();
    endtask

    // Compare the logged capture offsets (relative to c0) and values.
    task automatic checkCaptures(input string name, input int c0, input int n,
                                 input int offs[8], input logic [15:0] pcs[8]);
        int actOff;
        logic [15:0] actPc;
        checkOutput({name, " count"}, capCyc.size(), n);
        for (int i = 0; i < n; i++) begin
            actOff = (i < capCyc.size()) ? capCyc[i] - c0 : -1;
            actPc  = (i < capPc.size()) ? capPc[i] : 16'hxxxx;
            checkOutput($sformatf("%s offset%0d", name, i), actOff, offs[i]);
            checkOutput($sformatf("%s value%0d", name, i), {16'h0, actPc}, {16'h0, pcs[i]});
        end
    endtask

    initial begin
        int          c0;
        int          offs[8];
        logic [15:0] pcs[8];
        logic [5:0]  pat;
        logic [31:0] base;
        logic [31:0] tmp;

        checkCount = 0;
        passCount  = 0;
        reset = 1'b1;
        btn   = 1'b0;
        sw    = 1'b0;
        pc_in = 32'h0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkOutput("reset pc_out", {16'h0, pc_out}, 32'h0);
        checkOutput("reset capture", {31'h0, capture}, 32'h0);
        checkOutput("reset valid", {31'h0, valid}, 32'h0);

        // ---------------- bounce reject ----------------
        clearLog();
        pat = 6'b011011;
        for (int n = 0; n < 30; n++) applyStimulus(pat[n % 6], 1'b0, 32'h55556666);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h55556666);
        checkOutput("bounce captures", capCyc.size(), 0);
        checkOutput("bounce pc_out", {16'h0, pc_out}, 32'h0);
        checkOutput("bounce valid", {31'h0, valid}, 32'h0);

        // ---------------- upper half, table driven ----------------
        // Rows 0-2 let sw settle through the synchroniser, rows 3-8 hold the
        // button, row 9 is the decision cycle whose pc_in is sampled. After
        // that sw and pc_in change but pc_out must not follow.
        for (int i = 0; i < 18; i++) begin
            vecs[i].btn      = (i >= 3 && i <= 8);
            vecs[i].sw       = (i <= 9);
            vecs[i].pc       = (i <= 9) ? 32'hDEAD0042 : 32'h11112222;
            vecs[i].expCap   = (i == 9);
            vecs[i].expValid = (i >= 9);
            vecs[i].expPc    = (i >= 9) ? 16'hDEAD : 16'h0000;
        end
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].btn, vecs[i].sw, vecs[i].pc);
            checkOutput($sformatf("row%0d capture", i), {31'h0, capture}, {31'h0, vecs[i].expCap});
            checkOutput($sformatf("row%0d valid", i), {31'h0, valid}, {31'h0, vecs[i].expValid});
            checkOutput($sformatf("row%0d pc_out", i), {16'h0, pc_out}, {16'h0, vecs[i].expPc});
        end
        repeat (5) applyStimulus(1'b0, 1'b0, 32'h11112222);

        // ---------------- clean press with hold/repeat ----------------
        clearLog();
        c0 = cyc;
        for (int n = 1; n <= 55; n++) applyStimulus(n <= 40, 1'b0, 32'h1234ABCD);
        offs = '{7, 23, 31, 39, 0, 0, 0, 0};
        pcs  = '{16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0};
        checkCaptures("clean", c0, 4, offs, pcs);
        checkOutput("clean valid", {31'h0, valid}, 32'h1);
        checkOutput("clean pc_out", {16'h0, pc_out}, 32'h0000ABCD);

        // ---------------- release bounce ----------------
        clearLog();
        c0 = cyc;
        for (int n = 1; n <= 22; n++)
            applyStimulus((n <= 8) || (n == 11) || (n == 12), 1'b0, 32'hCAFE0001);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'hCAFE0001);
        offs = '{7, 0, 0, 0, 0, 0, 0, 0};
        pcs  = '{16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        checkCaptures("relbounce", c0, 1, offs, pcs);

        // A fresh press must debounce from IDLE again.
        clearLog();
        c0 = cyc;
        for (int n = 1; n <= 18; n++) applyStimulus(n <= 8, 1'b0, 32'hBEEF0002);
        pcs = '{16'h0002, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        checkCaptures("repress", c0, 1, offs, pcs);

        // ---------------- repeat tracking ----------------
        clearLog();
        base = 32'h0001FFF0;
        c0 = cyc;
        for (int n = 1; n <= 75; n++) applyStimulus(n <= 60, 1'b0, base + 32'(4 * n));
        offs = '{7, 23, 31, 39, 47, 55, 0, 0};
        for (int i = 0; i < 8; i++) begin
            tmp    = base + 32'(4 * offs[i]);
            pcs[i] = tmp[15:0];
        end
        checkCaptures("repeat", c0, 6, offs, pcs);

        // ---------------- async reset mid-press ----------------
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h00007777);
        #2;
        reset = 1'b1;
        #1;
        clearLog();
        checkOutput("async pc_out", {16'h0, pc_out}, 32'h0);
        checkOutput("async valid", {31'h0, valid}, 32'h0);
        checkOutput("async capture", {31'h0, capture}, 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        c0 = cyc;
        for (int n = 1; n <= 12; n++) applyStimulus(1'b1, 1'b0, 32'h00007777);
        offs = '{7, 0, 0, 0, 0, 0, 0, 0};
        pcs  = '{16'h7777, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        checkCaptures("postreset", c0, 1, offs, pcs);
        checkOutput("postreset valid", {31'h0, valid}, 32'h1);
        repeat (10) applyStimulus(1'b0, 1'b0, 32'h00007777);

        checkOutput("adjacent captures", adjErr, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
